// File: rtl/ireg_pkg.sv
// Shared types and widths for the integer register-file
// write-port scheduler.
package ireg_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } wbs_state_t;
endpackage

// File: rtl/ireg_scoreboard.sv
// Busy bits and outstanding count for multi-cycle results;
// raises decode stall on RAW/WAW against pending registers.
module ireg_scoreboard
  import ireg_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_v_i,
  input  logic [REG_IDX_W-1:0] issue_rd_i,
  output logic                 issue_ready_o,
  input  logic                 dec_i,
  input  logic                 clr_v_i,
  input  logic [REG_IDX_W-1:0] clr_rd_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 rs1_v_i,
  input  logic                 rs2_v_i,
  input  logic                 rd_v_i,
  output logic                 stall_sb_o,
  output logic [31:0]          busy_vec_o
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  assign issue_ready_o = (issue_rd_i == '0 || !busy_q[issue_rd_i])
                      && (cnt_q < CW'(MAX_OUT));
  assign fire = issue_v_i && issue_ready_o;

  // Bit 0 is never set, so x0 always reads not-busy.
  assign stall_sb_o = (rs1_v_i && busy_q[rs1_i])
                   || (rs2_v_i && busy_q[rs2_i])
                   || (rd_v_i  && busy_q[rd_i]);
  assign busy_vec_o = busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_v_i)
      busy_d[clr_rd_i] = 1'b0;
    if (fire && issue_rd_i != '0)
      busy_d[issue_rd_i] = 1'b1;
    cnt_d = cnt_q;
    case ({fire, dec_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/ireg_wb_sched.sv
// Merges pipeline and multi-cycle results onto the single
// register-file write port; forces bubbles if the unit starves.
module ireg_wb_sched
  import ireg_pkg::*;
#(
  parameter int XLEN     = ireg_pkg::XLEN,
  parameter int MAX_WAIT = 4,
  parameter int MAX_OUT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_we,
  input  logic [REG_IDX_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  input  logic                 issue_v,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_ready,
  input  logic                 div_valid,
  input  logic [REG_IDX_W-1:0] div_rd,
  input  logic [XLEN-1:0]      div_data,
  output logic                 div_ready,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 rs1_v,
  input  logic                 rs2_v,
  input  logic                 rd_v,
  output logic                 stall_sb,
  output logic                 pipe_hold,
  output logic                 wr_v,
  output logic [REG_IDX_W-1:0] wr_rd,
  output logic [XLEN-1:0]      wr_data,
  output logic [31:0]          busy_vec
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic                 pipe_wr, div_hs, div_lose;
  logic                 wr_v_q, wr_div_q, pipe_hold_q;
  logic [REG_IDX_W-1:0] wr_rd_q;
  logic [XLEN-1:0]      wr_data_q;
  wbs_state_t           state_q;
  logic [WW-1:0]        wait_cnt_q;

  // Pipeline cannot stall at writeback, so it always wins.
  assign pipe_wr   = pipe_we && pipe_rd != '0;
  assign div_ready = !pipe_wr;
  assign div_hs    = div_valid && div_ready;
  assign div_lose  = div_valid && !div_ready;

  assign wr_v      = wr_v_q;
  assign wr_rd     = wr_rd_q;
  assign wr_data   = wr_data_q;
  assign pipe_hold = pipe_hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_v_q    <= 1'b0;
      wr_div_q  <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else if (pipe_wr) begin
      wr_v_q    <= 1'b1;
      wr_div_q  <= 1'b0;
      wr_rd_q   <= pipe_rd;
      wr_data_q <= pipe_data;
    end else if (div_hs && div_rd != '0) begin
      wr_v_q    <= 1'b1;
      wr_div_q  <= 1'b1;
      wr_rd_q   <= div_rd;
      wr_data_q <= div_data;
    end else begin
      wr_v_q   <= 1'b0;
      wr_div_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      pipe_hold_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_lose) begin
            state_q    <= WAIT;
            wait_cnt_q <= WW'(1);
          end
        end
        WAIT: begin
          if (div_lose) begin
            if (wait_cnt_q == WW'(MAX_WAIT)) begin
              state_q     <= HOLD;
              pipe_hold_q <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end else begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end
        end
        HOLD: begin
          if (!div_lose) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            pipe_hold_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          wait_cnt_q  <= '0;
          pipe_hold_q <= 1'b0;
        end
      endcase
    end
  end

  ireg_scoreboard #(.MAX_OUT(MAX_OUT)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_v_i    (issue_v),
    .issue_rd_i   (issue_rd),
    .issue_ready_o(issue_ready),
    .dec_i        (div_hs),
    .clr_v_i      (wr_v_q && wr_div_q),
    .clr_rd_i     (wr_rd_q),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .rd_i         (rd),
    .rs1_v_i      (rs1_v),
    .rs2_v_i      (rs2_v),
    .rd_v_i       (rd_v),
    .stall_sb_o   (stall_sb),
    .busy_vec_o   (busy_vec)
  );
endmodule

// File: tb/tb_ireg_wb_sched.sv
// Directed bench for ireg_wb_sched: write-port scoreboard queue
// plus immediate checks on handshake, stall and hold outputs.
module tb_ireg_wb_sched;
  localparam int MAX_WAIT = 4;
  localparam int MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        div_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_v, rs2_v, rd_v;
  logic        stall_sb, pipe_hold, wr_v;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  ireg_wb_sched #(.XLEN(32), .MAX_WAIT(MAX_WAIT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .issue_v(issue_v), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data),
    .div_ready(div_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .rd_v(rd_v),
    .stall_sb(stall_sb), .pipe_hold(pipe_hold),
    .wr_v(wr_v), .wr_rd(wr_rd), .wr_data(wr_data),
    .busy_vec(busy_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.rd = r;
    e.d  = d;
    q.push_back(e);
  endtask

  // Write-port monitor: every write must match the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_v === 1'b1) begin
      chk("wr_not_x0", {31'b0, wr_rd != 5'd0}, 32'd1);
      chk("wr_expected", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        wr_t e;
        e = q.pop_front();
        chk("wr_rd", {27'b0, wr_rd}, {27'b0, e.rd});
        chk("wr_data", wr_data, e.d);
      end
    end
  end

  initial begin
    int n;
    logic got;
    rst_n = 1'b0;
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    issue_v = 0; issue_rd = 0;
    div_valid = 0; div_rd = 0; div_data = 0;
    rs1 = 0; rs2 = 0; rd = 0; rs1_v = 0; rs2_v = 0; rd_v = 0;
    #1;
    chk("rst_wr_v", {31'b0, wr_v}, 32'd0);
    chk("rst_wr_rd", {27'b0, wr_rd}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_hold", {31'b0, pipe_hold}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain pipeline write.
    @(negedge clk);
    pipe_we = 1; pipe_rd = 5; pipe_data = 32'h11;
    #1 chk("pipe_blocks_div", {31'b0, div_ready}, 32'd0);
    push(5, 32'h11);
    @(negedge clk);
    pipe_we = 0;

    // Reset mid-stream.
    pipe_we = 1; pipe_rd = 6; pipe_data = 32'h66;
    issue_v = 1; issue_rd = 12;
    @(posedge clk);
    #2;
    chk("pre_rst_wv", {31'b0, wr_v}, 32'd1);
    chk("pre_rst_busy12", {31'b0, busy_vec[12]}, 32'd1);
    pipe_we = 0; issue_v = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_v", {31'b0, wr_v}, 32'd0);
    chk("mid_rst_wr_rd", {27'b0, wr_rd}, 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_busy", busy_vec, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW stall until the div result is written back.
    @(negedge clk);
    issue_v = 1; issue_rd = 7;
    #1 chk("issue7_ready", {31'b0, issue_ready}, 32'd1);
    @(negedge clk);
    issue_v = 0; rs1 = 7; rs1_v = 1;
    #1 chk("raw_stall", {31'b0, stall_sb}, 32'd1);
    @(negedge clk);
    div_valid = 1; div_rd = 7; div_data = 32'hABCD;
    #1 chk("div7_ready", {31'b0, div_ready}, 32'd1);
    push(7, 32'hABCD);
    @(negedge clk);
    div_valid = 0;
    #1 chk("stall_during_wb", {31'b0, stall_sb}, 32'd1);
    @(negedge clk);
    #1 chk("stall_cleared", {31'b0, stall_sb}, 32'd0);
    chk("busy7_cleared", {31'b0, busy_vec[7]}, 32'd0);
    rs1_v = 0;

    // Pipeline write to x0 leaves the port to the div result.
    @(negedge clk);
    issue_v = 1; issue_rd = 9;
    @(negedge clk);
    issue_v = 0;
    pipe_we = 1; pipe_rd = 0; pipe_data = 32'h99;
    div_valid = 1; div_rd = 9; div_data = 32'h909;
    #1 chk("x0_div_ready", {31'b0, div_ready}, 32'd1);
    push(9, 32'h909);
    @(negedge clk);
    pipe_we = 0; div_valid = 0;
    @(negedge clk);
    #1 chk("busy9_cleared", {31'b0, busy_vec[9]}, 32'd0);

    // Starvation: pipeline keeps winning until a bubble is forced.
    @(negedge clk);
    issue_v = 1; issue_rd = 11;
    @(negedge clk);
    issue_v = 0;
    div_valid = 1; div_rd = 11; div_data = 32'hBEEF;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      pipe_we = 1; pipe_rd = 3; pipe_data = 32'h300 + i;
      push(3, 32'h300 + i);
      n++;
      @(negedge clk);
      got = pipe_hold;
    end
    chk("hold_set", {31'b0, got}, 32'd1);
    chk("hold_lose_cycles", n, MAX_WAIT + 1);
    pipe_we = 0;
    #1 chk("hold_div_ready", {31'b0, div_ready}, 32'd1);
    push(11, 32'hBEEF);
    @(negedge clk);
    div_valid = 0;
    #1 chk("hold_dropped", {31'b0, pipe_hold}, 32'd0);
    @(negedge clk);

    // Outstanding limit and WAW stall.
    issue_v = 1; issue_rd = 4;
    #1 chk("issue4_ready", {31'b0, issue_ready}, 32'd1);
    @(negedge clk);
    issue_rd = 6;
    #1 chk("issue6_ready", {31'b0, issue_ready}, 32'd1);
    @(negedge clk);
    issue_rd = 8;
    #1 chk("issue8_full", {31'b0, issue_ready}, 32'd0);
    @(negedge clk);
    issue_v = 0; rd = 6; rd_v = 1;
    #1 chk("waw_stall", {31'b0, stall_sb}, 32'd1);
    @(negedge clk);
    rd_v = 0;
    div_valid = 1; div_rd = 6; div_data = 32'h6666;
    push(6, 32'h6666);
    @(negedge clk);
    div_valid = 0;
    issue_v = 1; issue_rd = 4;
    #1 chk("issue4_busy", {31'b0, issue_ready}, 32'd0);

    // Issue and retirement in the same cycle.
    @(negedge clk);
    issue_rd = 10;
    div_valid = 1; div_rd = 4; div_data = 32'h4444;
    #1 chk("same_issue_ready", {31'b0, issue_ready}, 32'd1);
    chk("same_div_ready", {31'b0, div_ready}, 32'd1);
    push(4, 32'h4444);
    @(negedge clk);
    div_valid = 0;
    issue_rd = 4;
    #1 chk("busy10_set", {31'b0, busy_vec[10]}, 32'd1);
    chk("busy4_at_wb", {31'b0, busy_vec[4]}, 32'd1);
    chk("issue_on_clearing", {31'b0, issue_ready}, 32'd0);
    @(negedge clk);
    issue_rd = 13;
    #1 chk("busy4_cleared", {31'b0, busy_vec[4]}, 32'd0);
    chk("issue13_ready", {31'b0, issue_ready}, 32'd1);
    @(negedge clk);
    issue_rd = 14;
    #1 chk("issue14_full", {31'b0, issue_ready}, 32'd0);
    @(negedge clk);
    issue_v = 0;
    #1 chk("busy_final", busy_vec, 32'h0000_2400);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
